bit_serial_alu_ctrl: RTL

Sequencer that evaluates a WIDTH-bit ALU operation on one shared 1-bit ALU slice, one bit per clock, LSB first.
The slice supports A/B invert, carry-in, a 2-bit operation select (00 AND, 01 OR, 10 ADD, 11 LESS) and carry-out.
The controller captures the operands, drives the slice's invert, carry and select controls bit by bit, and assembles the result and flags.
It replaces a parallel 32-slice ALU in area-constrained configurations of the single-cycle/pipelined CPU datapath.

---
 rtl/bit_serial_alu_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: evaluates one WIDTH-bit operation on a single 1-bit
// ALU slice, LSB first, one bit per clock, then publishes result and flags.
module bit_serial_alu_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDXW  = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_LOGIC = 2'd0,
        CLS_ARITH = 2'd1,
        CLS_SLT   = 2'd2,
        CLS_UNSUP = 2'd3
    } op_class_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NAND = 4'b1101;

    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_ADD  = 2'b10;
    localparam logic [1:0] SEL_LESS = 2'b11;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             cout_d;
    logic             overflow_d;
    logic             busy_d;
    logic             done_d;

    logic [1:0]       op_sel;
    op_class_t        op_class;
    logic             a_bit;
    logic             b_bit;
    logic             slice_sum;
    logic             slice_cout;
    logic             slice_res;
    logic [WIDTH-1:0] res_shift;
    logic             carry_in_msb;
    logic             sum_msb;
    logic             ovf;
    logic             slt_set;

    // Slice operation select and result-assembly class from the latched ctrl
    always_comb begin
        op_sel   = SEL_AND;
        op_class = CLS_UNSUP;
        case (ctrl_q)
            CTRL_AND, CTRL_NOR: begin
                op_sel   = SEL_AND;
                op_class = CLS_LOGIC;
            end
            CTRL_OR, CTRL_NAND: begin
                op_sel   = SEL_OR;
                op_class = CLS_LOGIC;
            end
            CTRL_ADD, CTRL_SUB: begin
                op_sel   = SEL_ADD;
                op_class = CLS_ARITH;
            end
            CTRL_SLT: begin
                op_sel   = SEL_ADD;
                op_class = CLS_SLT;
            end
            default: begin
                op_sel   = SEL_AND;
                op_class = CLS_UNSUP;
            end
        endcase
    end

    // Shared 1-bit ALU slice; operands are shifted so bit idx is always at [0]
    always_comb begin
        a_bit      = a_q[0] ^ ctrl_q[3];
        b_bit      = b_q[0] ^ ctrl_q[2];
        slice_sum  = a_bit ^ b_bit ^ carry_q;
        slice_cout = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
        case (op_sel)
            SEL_AND:  slice_res = a_bit & b_bit;
            SEL_OR:   slice_res = a_bit | b_bit;
            SEL_ADD:  slice_res = slice_sum;
            SEL_LESS: slice_res = 1'b0;
            default:  slice_res = 1'b0;
        endcase
    end

    always_comb begin
        res_shift    = {slice_res, res_q[WIDTH-1:1]};
        carry_in_msb = carry_q;
        sum_msb      = slice_sum;
        ovf          = slice_cout ^ carry_in_msb;
        slt_set      = sum_msb ^ ovf;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        ctrl_d     = ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        result_d   = result_o;
        zero_d     = zero_o;
        cout_d     = cout_o;
        overflow_d = overflow_o;
        busy_d     = busy_o;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ctrl_d  = ctrl_i;
                    a_d     = src1_i;
                    b_d     = src2_i;
                    idx_d   = '0;
                    carry_d = ctrl_i[2];
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = slice_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                    case (op_class)
                        CLS_LOGIC: begin
                            result_d   = res_shift;
                            cout_d     = 1'b0;
                            overflow_d = 1'b0;
                        end
                        CLS_ARITH: begin
                            result_d   = res_shift;
                            cout_d     = slice_cout;
                            overflow_d = ovf;
                        end
                        CLS_SLT: begin
                            result_d   = {{(WIDTH-1){1'b0}}, slt_set};
                            cout_d     = 1'b0;
                            overflow_d = 1'b0;
                        end
                        default: begin
                            result_d   = '0;
                            cout_d     = 1'b0;
                            overflow_d = 1'b0;
                        end
                    endcase
                    zero_d = (result_d == '0);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            ctrl_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            ctrl_q     <= ctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            result_o   <= result_d;
            zero_o     <= zero_d;
            cout_o     <= cout_d;
            overflow_o <= overflow_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
        end
    end

endmodule
